// File: rtl/mem_defs_pkg.sv
// Shared types and helpers for the load/store queue ID allocator.
// Queue depths here size the ID and pointer types used at the ports.
package mem_defs_pkg;

    localparam int LDQ_NUM_ENTRIES = 4;
    localparam int STQ_NUM_ENTRIES = 4;

    localparam int LDQ_IDX_W = $clog2(LDQ_NUM_ENTRIES);
    localparam int STQ_IDX_W = $clog2(STQ_NUM_ENTRIES);

    typedef logic [LDQ_IDX_W-1:0] t_ldq_id;
    typedef logic [STQ_IDX_W-1:0] t_stq_id;

    typedef struct packed {
        logic    wrap;
        t_ldq_id id;
    } t_ldq_ptr;

    typedef struct packed {
        logic    wrap;
        t_stq_id id;
    } t_stq_ptr;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    // Occupancy of a ring whose pointers are idx_w+1 bits wide.
    function automatic logic [31:0] ptr_count(
        input logic [31:0] head,
        input logic [31:0] tail,
        input int unsigned idx_w
    );
        logic [31:0] mask;
        mask = (32'd1 << (idx_w + 1)) - 32'd1;
        return (tail - head) & mask;
    endfunction

endpackage

// File: rtl/memq_id_ring.sv
// One in-order ID ring: head/tail pointers with a wrap bit.
// Allocation advances the tail, retirement the head, flush rewinds the tail.
module memq_id_ring
    import mem_defs_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc,
    input  logic                 retire,
    input  logic                 flush,
    output logic [$clog2(N)-1:0] tail_idx,
    output logic [$clog2(N):0]   count,
    output logic                 full
);

    localparam int W = $clog2(N);

    logic [W:0] head_q, head_d;
    logic [W:0] tail_q, tail_d;
    logic       empty;

    always_comb begin
        head_d = head_q + {{W{1'b0}}, retire};
        tail_d = tail_q + {{W{1'b0}}, alloc};
        // Flush keeps only what survives this cycle's retires.
        if (flush) begin
            tail_d = head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        empty    = (head_q == tail_q);
        full     = (head_q[W-1:0] == tail_q[W-1:0])
                 & (head_q[W] != tail_q[W]);
        tail_idx = tail_q[W-1:0];
        count    = (W+1)'(ptr_count(32'(head_q), 32'(tail_q), W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(retire && empty))
            else $error("memq_id_ring: retire on empty ring");
        end
    end

endmodule

// File: rtl/memq_id_alloc.sv
// Rename-stage LDQ/STQ ID allocator with youngest-older-store tagging.
// MEMQ_ALLOC_HWM_EN adds occupancy high-water-mark outputs.
module memq_id_alloc
    import mem_defs_pkg::*;
#(
    parameter int LDQ_N = LDQ_NUM_ENTRIES,
    parameter int STQ_N = STQ_NUM_ENTRIES
) (
    input  logic            clk,
    input  logic            reset,
    input  t_nuke_pkt       nuke_rb1,
    input  logic            alloc_rn0,
    input  logic            alloc_ld_rn0,
    input  logic            alloc_st_rn0,
    output logic            alloc_gnt_rn0,
    output t_ldq_id         ldqid_rn0,
    output t_stq_id         stqid_rn0,
    input  logic            ret_ld_rb0,
    input  logic            ret_st_rb0,
    output logic            ldq_full,
    output logic            stq_full,
`ifdef MEMQ_ALLOC_HWM_EN
    output logic [LDQ_IDX_W:0] ldq_hwm,
    output logic [STQ_IDX_W:0] stq_hwm,
`endif
    output logic            idle
);

    if (LDQ_N != LDQ_NUM_ENTRIES || STQ_N != STQ_NUM_ENTRIES) begin : g_bad_cfg
        $error("memq_id_alloc: depths must match mem_defs_pkg");
    end

    logic               gnt;
    logic               ld_alloc;
    logic               st_alloc;
    logic               ldq_full_r;
    logic               stq_full_r;
    t_ldq_id            ldq_tail;
    t_stq_id            stq_tail;
    logic [LDQ_IDX_W:0] ldq_cnt;
    logic [STQ_IDX_W:0] stq_cnt;

    always_comb begin
        gnt = reset & alloc_rn0 & ~nuke_rb1.valid
            & ~(alloc_ld_rn0 & ldq_full_r)
            & ~(alloc_st_rn0 & stq_full_r);
        ld_alloc = gnt & alloc_ld_rn0;
        st_alloc = gnt & alloc_st_rn0;
    end

    memq_id_ring #(.N(LDQ_N)) u_ldq (
        .clk      (clk),
        .reset    (reset),
        .alloc    (ld_alloc),
        .retire   (ret_ld_rb0),
        .flush    (nuke_rb1.valid),
        .tail_idx (ldq_tail),
        .count    (ldq_cnt),
        .full     (ldq_full_r)
    );

    memq_id_ring #(.N(STQ_N)) u_stq (
        .clk      (clk),
        .reset    (reset),
        .alloc    (st_alloc),
        .retire   (ret_st_rb0),
        .flush    (nuke_rb1.valid),
        .tail_idx (stq_tail),
        .count    (stq_cnt),
        .full     (stq_full_r)
    );

    // Ring state is masked while reset is held so outputs read as empty.
    always_comb begin
        alloc_gnt_rn0 = gnt;
        ldqid_rn0     = reset ? ldq_tail : '0;
        stqid_rn0     = reset ? stq_tail : '0;
        if (alloc_ld_rn0) begin
            stqid_rn0 = stqid_rn0 - STQ_IDX_W'(1);
        end
        ldq_full = reset & ldq_full_r;
        stq_full = reset & stq_full_r;
        idle     = ~reset | ((ldq_cnt == '0) & (stq_cnt == '0));
    end

`ifdef MEMQ_ALLOC_HWM_EN
    logic [LDQ_IDX_W:0] ldq_hwm_q, ldq_hwm_d;
    logic [STQ_IDX_W:0] stq_hwm_q, stq_hwm_d;

    always_comb begin
        ldq_hwm_d = (ldq_cnt > ldq_hwm_q) ? ldq_cnt : ldq_hwm_q;
        stq_hwm_d = (stq_cnt > stq_hwm_q) ? stq_cnt : stq_hwm_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ldq_hwm_q <= '0;
            stq_hwm_q <= '0;
        end else begin
            ldq_hwm_q <= ldq_hwm_d;
            stq_hwm_q <= stq_hwm_d;
        end
    end

    assign ldq_hwm = ldq_hwm_q;
    assign stq_hwm = stq_hwm_q;
`endif

endmodule

// File: tb/tb_memq_id_alloc.sv
// Randomized bench for memq_id_alloc against a counter-based queue model.
// Build with MEMQ_ALLOC_HWM_EN to also check the high-water marks.
module tb_memq_id_alloc;
    import mem_defs_pkg::*;

    localparam int LN = LDQ_NUM_ENTRIES;
    localparam int SN = STQ_NUM_ENTRIES;

    logic      clk = 1'b0;
    logic      reset = 1'b0;
    t_nuke_pkt nuke = '0;
    logic      alloc = 1'b0;
    logic      ald = 1'b0;
    logic      ast = 1'b0;
    logic      rl = 1'b0;
    logic      rs = 1'b0;
    logic      gnt_o;
    t_ldq_id   ldqid_o;
    t_stq_id   stqid_o;
    logic      ldq_full_o;
    logic      stq_full_o;
    logic      idle_o;
`ifdef MEMQ_ALLOC_HWM_EN
    logic [LDQ_IDX_W:0] ldq_hwm_o;
    logic [STQ_IDX_W:0] stq_hwm_o;
`endif

    memq_id_alloc dut (
        .clk           (clk),
        .reset         (reset),
        .nuke_rb1      (nuke),
        .alloc_rn0     (alloc),
        .alloc_ld_rn0  (ald),
        .alloc_st_rn0  (ast),
        .alloc_gnt_rn0 (gnt_o),
        .ldqid_rn0     (ldqid_o),
        .stqid_rn0     (stqid_o),
        .ret_ld_rb0    (rl),
        .ret_st_rb0    (rs),
        .ldq_full      (ldq_full_o),
        .stq_full      (stq_full_o),
`ifdef MEMQ_ALLOC_HWM_EN
        .ldq_hwm       (ldq_hwm_o),
        .stq_hwm       (stq_hwm_o),
`endif
        .idle          (idle_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: unbounded allocate/retire counters per queue.
    int ld_h = 0, ld_t = 0, st_h = 0, st_t = 0;
    int ld_hwm = 0, st_hwm = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit m_gnt();
        return reset && alloc && !nuke.valid
            && !(ald && (ld_t - ld_h) == LN)
            && !(ast && (st_t - st_h) == SN);
    endfunction

    always @(posedge clk) begin : model
        bit g;
        if (!reset) begin
            ld_h = 0; ld_t = 0; st_h = 0; st_t = 0;
            ld_hwm = 0; st_hwm = 0;
        end else begin
            g = m_gnt();
            if (ld_t - ld_h > ld_hwm) ld_hwm = ld_t - ld_h;
            if (st_t - st_h > st_hwm) st_hwm = st_t - st_h;
            ld_h += int'(rl);
            st_h += int'(rs);
            if (nuke.valid) begin
                ld_t = ld_h;
                st_t = st_h;
            end else if (g) begin
                ld_t += int'(ald);
                st_t += int'(ast);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit g;
        g = m_gnt();
        chk("gnt", int'(gnt_o), int'(g));
        chk("ldq_full", int'(ldq_full_o),
            int'(reset && (ld_t - ld_h) == LN));
        chk("stq_full", int'(stq_full_o),
            int'(reset && (st_t - st_h) == SN));
        chk("idle", int'(idle_o),
            int'(!reset || (ld_t == ld_h && st_t == st_h)));
        if (!reset) begin
            chk("rst_ldqid", int'(ldqid_o), 0);
            chk("rst_stqid", int'(stqid_o), ald ? SN - 1 : 0);
        end else if (g && gnt_o) begin
            if (ald) begin
                chk("ldqid", int'(ldqid_o), ld_t % LN);
                chk("yost", int'(stqid_o), (st_t + SN - 1) % SN);
            end
            if (ast) chk("stqid", int'(stqid_o), st_t % SN);
        end
`ifdef MEMQ_ALLOC_HWM_EN
        chk("ldq_hwm", int'(ldq_hwm_o), ld_hwm);
        chk("stq_hwm", int'(stq_hwm_o), st_hwm);
`endif
    end

    task automatic drv(input bit a, input bit l, input bit s,
                       input bit r_l, input bit r_s, input bit nk);
        alloc = a; ald = l; ast = s;
        rl = r_l; rs = r_s; nuke.valid = nk;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset values and first load
        reset = 1'b0;
        drv(1, 1, 0, 0, 0, 0);
        chk("t1_rst_gnt", int'(gnt_o), 0);
        chk("t1_rst_idle", int'(idle_o), 1);
        chk("t1_rst_yost", int'(stqid_o), 3);
        step();
        drv(0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        chk("t1_idle", int'(idle_o), 1);
        chk("t1_ldq_full", int'(ldq_full_o), 0);
        chk("t1_stq_full", int'(stq_full_o), 0);
        step();
        drv(1, 1, 0, 0, 0, 0);
        chk("t1_gnt", int'(gnt_o), 1);
        chk("t1_ldqid", int'(ldqid_o), 0);
        chk("t1_yost", int'(stqid_o), 3);
        step();

        // 2: st, st, ld
        do_reset();
        drv(1, 0, 1, 0, 0, 0);
        chk("t2_st0", int'(stqid_o), 0);
        step();
        drv(1, 0, 1, 0, 0, 0);
        chk("t2_st1", int'(stqid_o), 1);
        step();
        drv(1, 1, 0, 0, 0, 0);
        chk("t2_ldqid", int'(ldqid_o), 0);
        chk("t2_yost", int'(stqid_o), 1);
        step();
        drv(0, 0, 0, 0, 0, 0);
        chk("t2_idle", int'(idle_o), 0);
        step();

        // 3: fill the LDQ
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 0, 0, 0, 0);
            if (i < 4) begin
                chk("t3_gnt", int'(gnt_o), 1);
                chk("t3_ldqid", int'(ldqid_o), i);
            end else begin
                chk("t3_gnt5", int'(gnt_o), 0);
                chk("t3_full", int'(ldq_full_o), 1);
            end
            step();
        end

        // 4: retire does not bypass full
        drv(1, 1, 0, 1, 0, 0);
        chk("t4_gnt_blk", int'(gnt_o), 0);
        step();
        drv(1, 1, 0, 0, 0, 0);
        chk("t4_gnt", int'(gnt_o), 1);
        chk("t4_wrap_id", int'(ldqid_o), 0);
        step();

        // 5: nuke with same-cycle retire and alloc
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 0, 0, 0);
            step();
        end
        drv(1, 1, 0, 1, 0, 1);
        chk("t5_gnt", int'(gnt_o), 0);
        step();
        drv(0, 0, 0, 0, 0, 0);
        chk("t5_idle", int'(idle_o), 1);
        step();
        drv(1, 1, 0, 0, 0, 0);
        chk("t5_gnt2", int'(gnt_o), 1);
        chk("t5_ldqid", int'(ldqid_o), 1);
        step();

`ifdef MEMQ_ALLOC_HWM_EN
        // 6: high-water mark survives nuke, cleared by reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 0, 0, 0);
            step();
        end
        drv(0, 0, 0, 1, 0, 0);
        step();
        drv(0, 0, 0, 1, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 1);
        step();
        drv(0, 0, 0, 0, 0, 0);
        step();
        drv(0, 0, 0, 0, 0, 0);
        chk("t6_hwm", int'(ldq_hwm_o), 3);
        step();
        do_reset();
        drv(0, 0, 0, 0, 0, 0);
        chk("t6_hwm_rst", int'(ldq_hwm_o), 0);
        step();
`endif

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            int k;
            bit a, l, s, r_l, r_s, nk;
            reset = ($urandom_range(0, 299) != 0);
            k = int'($urandom_range(0, 3));
            a = (k != 0);
            l = (k == 1);
            s = (k == 2);
            r_l = (ld_t > ld_h) && ($urandom_range(0, 2) == 0);
            r_s = (st_t > st_h) && ($urandom_range(0, 2) == 0);
            nk = ($urandom_range(0, 39) == 0);
            drv(a, l, s, r_l, r_s, nk);
            step();
        end
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
